tpu_sequencer: RTL and testbench

Sequences one weight-load-and-multiply pass through `top`. On a single `start` pulse it drives, in order: the weight memory read burst into the weight FIFOs, the FIFO-to-array weight transfer, and the `active` multiply window. It then waits for the output write-back and reports completion. It replaces hand-driven control of `top` and sits directly between the host/command logic and `top`'s control ports.

---
 rtl/tpu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tpu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: runs one weight-load-and-multiply pass through `top` per `start` pulse.
//
// Sequence: IDLE -> WLOAD (WIDTH_HEIGHT read cycles) -> WFIFO (wait mem_to_fifo_done)
//           -> F2A (wait fifo_to_arr_done) -> COMPUTE (ACTIVE_CYCLES cycles)
//           -> WOUT (wait output_done) -> DONE (one cycle) -> IDLE.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   start                          pass request, sampled only in IDLE
//   weight_base/input_base/
//   output_base                    8-bit base addresses, latched when start is accepted
//   mem_to_fifo_done/fifo_to_arr_done/output_done
//                                  completion strobes from `top`, honoured in their wait state
//   weightMem_rd_en/_rd_addr       weight memory burst (per-lane enable / 8-bit address)
//   mem_to_fifo, fifo_to_arr,
//   weight_write, active           `top` control strobes
//   inputMem_rd_addr_base,
//   outputMem_wr_addr_base         latched bases replicated per lane while busy
//   busy, done, error              status (error only with the watchdog)
//
// Optional feature: define SEQ_TIMEOUT_EN to enable the wait-state watchdog.
// All outputs are registered and derived from the next state, so they line up with the state.
module tpu_sequencer #(
    parameter int WIDTH_HEIGHT   = 16,
    parameter int ACTIVE_CYCLES  = 19,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                weight_base,
    input  logic [7:0]                input_base,
    input  logic [7:0]                output_base,
    input  logic                      mem_to_fifo_done,
    input  logic                      fifo_to_arr_done,
    input  logic                      output_done,
    output logic [WIDTH_HEIGHT-1:0]   weightMem_rd_en,
    output logic [WIDTH_HEIGHT*8-1:0] weightMem_rd_addr,
    output logic                      mem_to_fifo,
    output logic                      fifo_to_arr,
    output logic [WIDTH_HEIGHT-1:0]   weight_write,
    output logic                      active,
    output logic [WIDTH_HEIGHT*8-1:0] inputMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*8-1:0] outputMem_wr_addr_base,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int CNT_MAX = (WIDTH_HEIGHT > ACTIVE_CYCLES) ? WIDTH_HEIGHT : ACTIVE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BUS_W   = WIDTH_HEIGHT * 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WLOAD   = 3'd1;
    localparam logic [2:0] S_WFIFO   = 3'd2;
    localparam logic [2:0] S_F2A     = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_WOUT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       wbase_q, wbase_d;
    logic [7:0]       ibase_q, ibase_d;
    logic [7:0]       obase_q, obase_d;
    logic             accept;
    logic [7:0]       rd_lane;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            waiting;
    logic            timeout;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WLOAD;
                    accept  = 1'b1;
                end
            end
            S_WLOAD:   if (cnt_q == CNT_W'(WIDTH_HEIGHT - 1)) state_d = S_WFIFO;
            S_WFIFO:   if (mem_to_fifo_done) state_d = S_F2A;
            S_F2A:     if (fifo_to_arr_done) state_d = S_COMPUTE;
            S_COMPUTE: if (cnt_q == CNT_W'(ACTIVE_CYCLES - 1)) state_d = S_WOUT;
            S_WOUT:    if (output_done) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

`ifdef SEQ_TIMEOUT_EN
        // A done strobe in the same cycle as expiry wins over the watchdog.
        waiting = (state_q == S_WFIFO) || (state_q == S_F2A) || (state_q == S_WOUT);
        timeout = waiting && (state_d == state_q) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        if (timeout) state_d = S_IDLE;
        if (state_d != state_q) wd_d = '0;
        else if (waiting)       wd_d = wd_q + WD_W'(1);
        else                    wd_d = wd_q;
`endif

        // Counters restart on every state entry; only the timed states advance them.
        if (state_d != state_q) cnt_d = '0;
        else if (state_q == S_WLOAD || state_q == S_COMPUTE) cnt_d = cnt_q + CNT_W'(1);
        else cnt_d = cnt_q;

        wbase_d = accept ? weight_base : wbase_q;
        ibase_d = accept ? input_base  : ibase_q;
        obase_d = accept ? output_base : obase_q;
        rd_lane = wbase_d + 8'(cnt_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                <= S_IDLE;
            cnt_q                  <= '0;
            wbase_q                <= '0;
            ibase_q                <= '0;
            obase_q                <= '0;
            weightMem_rd_en        <= '0;
            weightMem_rd_addr      <= '0;
            mem_to_fifo            <= 1'b0;
            fifo_to_arr            <= 1'b0;
            weight_write           <= '0;
            active                 <= 1'b0;
            inputMem_rd_addr_base  <= '0;
            outputMem_wr_addr_base <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
        end else begin
            state_q                <= state_d;
            cnt_q                  <= cnt_d;
            wbase_q                <= wbase_d;
            ibase_q                <= ibase_d;
            obase_q                <= obase_d;
            weightMem_rd_en        <= (state_d == S_WLOAD) ? '1 : '0;
            weightMem_rd_addr      <= (state_d == S_WLOAD) ? {WIDTH_HEIGHT{rd_lane}} : BUS_W'(0);
            mem_to_fifo            <= (state_d == S_WLOAD);
            fifo_to_arr            <= (state_d == S_F2A);
            weight_write           <= (state_d == S_F2A) ? '1 : '0;
            active                 <= (state_d == S_COMPUTE);
            inputMem_rd_addr_base  <= (state_d != S_IDLE) ? {WIDTH_HEIGHT{ibase_d}} : BUS_W'(0);
            outputMem_wr_addr_base <= (state_d != S_IDLE) ? {WIDTH_HEIGHT{obase_d}} : BUS_W'(0);
            busy                   <= (state_d != S_IDLE);
            done                   <= (state_d == S_DONE);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            error <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (accept)       error <= 1'b0;
            else if (timeout) error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer. A scripted pass model sets the expected outputs for
// every cycle; one negedge process compares all outputs against them.
module tb_tpu_sequencer;
    localparam int WH = 16;
    localparam int AC = 19;
    localparam int TO = 64;
    localparam int BW = WH * 8;

    localparam int PH_IDLE = 0, PH_WLOAD = 1, PH_WFIFO = 2, PH_F2A = 3;
    localparam int PH_COMPUTE = 4, PH_WOUT = 5, PH_DONE = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [7:0] weight_base = '0, input_base = '0, output_base = '0;
    logic mem_to_fifo_done = 1'b0, fifo_to_arr_done = 1'b0, output_done = 1'b0;

    logic [WH-1:0] weightMem_rd_en, weight_write;
    logic [BW-1:0] weightMem_rd_addr, inputMem_rd_addr_base, outputMem_wr_addr_base;
    logic mem_to_fifo, fifo_to_arr, active, busy, done, error;

    tpu_sequencer #(
        .WIDTH_HEIGHT  (WH),
        .ACTIVE_CYCLES (AC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .weight_base           (weight_base),
        .input_base            (input_base),
        .output_base           (output_base),
        .mem_to_fifo_done      (mem_to_fifo_done),
        .fifo_to_arr_done      (fifo_to_arr_done),
        .output_done           (output_done),
        .weightMem_rd_en       (weightMem_rd_en),
        .weightMem_rd_addr     (weightMem_rd_addr),
        .mem_to_fifo           (mem_to_fifo),
        .fifo_to_arr           (fifo_to_arr),
        .weight_write          (weight_write),
        .active                (active),
        .inputMem_rd_addr_base (inputMem_rd_addr_base),
        .outputMem_wr_addr_base(outputMem_wr_addr_base),
        .busy                  (busy),
        .done                  (done),
        .error                 (error)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle
    logic [WH-1:0] e_rd_en, e_ww;
    logic [BW-1:0] e_addr, e_ibus, e_obus;
    logic e_m2f, e_f2a, e_active, e_busy, e_done, e_error;
    logic model_err = 1'b0;
    logic [7:0] cur_wb, cur_ib, cur_ob;

    int checks = 0;
    int failures = 0;
    int m2f_cycles, active_cycles, done_count;
    logic [7:0] addr_log [0:WH-1];
    logic [BW-1:0] ibus_seen;

    function automatic logic [BW-1:0] rep(input logic [7:0] b);
        logic [BW-1:0] r;
        for (int i = 0; i < WH; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    function automatic void cmp(input string nm, input logic [BW-1:0] act,
                                input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Expected outputs of a pass, derived from the phase and the step within it.
    task automatic set_exp(input int ph, input int k);
        e_rd_en  = '0;
        e_addr   = '0;
        e_m2f    = 1'b0;
        e_f2a    = 1'b0;
        e_ww     = '0;
        e_active = 1'b0;
        e_done   = 1'b0;
        e_busy   = (ph != PH_IDLE);
        e_ibus   = (ph != PH_IDLE) ? rep(cur_ib) : '0;
        e_obus   = (ph != PH_IDLE) ? rep(cur_ob) : '0;
        e_error  = model_err;
        case (ph)
            PH_WLOAD: begin
                e_rd_en = '1;
                e_addr  = rep(cur_wb + 8'(k));
                e_m2f   = 1'b1;
            end
            PH_F2A: begin
                e_f2a = 1'b1;
                e_ww  = '1;
            end
            PH_COMPUTE: e_active = 1'b1;
            PH_DONE:    e_done = 1'b1;
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_noise();
        start            = 1'b0;
        mem_to_fifo_done = 1'b0;
        fifo_to_arr_done = 1'b0;
        output_done      = 1'b0;
    endtask

    always @(negedge clk) begin
        cmp("rd_en", BW'(weightMem_rd_en), BW'(e_rd_en));
        cmp("rd_addr", weightMem_rd_addr, e_addr);
        cmp("mem_to_fifo", BW'(mem_to_fifo), BW'(e_m2f));
        cmp("fifo_to_arr", BW'(fifo_to_arr), BW'(e_f2a));
        cmp("weight_write", BW'(weight_write), BW'(e_ww));
        cmp("active", BW'(active), BW'(e_active));
        cmp("in_base", inputMem_rd_addr_base, e_ibus);
        cmp("out_base", outputMem_wr_addr_base, e_obus);
        cmp("busy", BW'(busy), BW'(e_busy));
        cmp("done", BW'(done), BW'(e_done));
        cmp("error", BW'(error), BW'(e_error));
        if (mem_to_fifo) begin
            if (m2f_cycles < WH) addr_log[m2f_cycles] = weightMem_rd_addr[7:0];
            m2f_cycles++;
        end
        if (active) begin
            if (active_cycles == 0) ibus_seen = inputMem_rd_addr_base;
            active_cycles++;
        end
        if (done) done_count++;
    end

    task automatic reset_counts();
        m2f_cycles    = 0;
        active_cycles = 0;
        done_count    = 0;
    endtask

    // d3 < 0: output_done never arrives (watchdog case). abort_k >= 0: reset at that COMPUTE step.
    task automatic run_pass(input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                            input int d1, input int d2, input int d3,
                            input bit noisy, input int abort_k);
        set_exp(PH_IDLE, 0);
        weight_base = wb;
        input_base  = ib;
        output_base = ob;
        start       = 1'b1;
        step();
        start     = 1'b0;
        cur_wb    = wb;
        cur_ib    = ib;
        cur_ob    = ob;
        model_err = 1'b0;
        for (int k = 0; k < WH; k++) begin
            set_exp(PH_WLOAD, k);
            if (noisy) begin
                fifo_to_arr_done = (k == WH - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                output_done      = 1'($urandom_range(0, 1));
                start            = 1'($urandom_range(0, 1));
                weight_base      = 8'($urandom);
                input_base       = 8'($urandom);
                output_base      = 8'($urandom);
            end
            step();
        end
        clear_noise();
        for (int i = 0; i <= d1; i++) begin
            set_exp(PH_WFIFO, 0);
            mem_to_fifo_done = (i == d1);
            if (noisy) begin
                fifo_to_arr_done = 1'($urandom_range(0, 1));
                output_done      = 1'($urandom_range(0, 1));
            end
            step();
        end
        clear_noise();
        for (int i = 0; i <= d2; i++) begin
            set_exp(PH_F2A, 0);
            fifo_to_arr_done = (i == d2);
            if (noisy) begin
                mem_to_fifo_done = 1'($urandom_range(0, 1));
                output_done      = 1'($urandom_range(0, 1));
                start            = 1'($urandom_range(0, 1));
            end
            step();
        end
        clear_noise();
        for (int k = 0; k < AC; k++) begin
            set_exp(PH_COMPUTE, k);
            if (k == abort_k) begin
                #1 reset = 1'b1;
                model_err = 1'b0;
                set_exp(PH_IDLE, 0);
                #1;
                cmp("abort_active", BW'(active), BW'(1'b0));
                cmp("abort_busy", BW'(busy), BW'(1'b0));
                cmp("abort_in_base", inputMem_rd_addr_base, '0);
                step();
                step();
                reset = 1'b0;
                step();
                return;
            end
            if (noisy) begin
                start            = (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                mem_to_fifo_done = 1'($urandom_range(0, 1));
                fifo_to_arr_done = 1'($urandom_range(0, 1));
                output_done      = 1'($urandom_range(0, 1));
            end
            step();
        end
        clear_noise();
        if (d3 < 0) begin
            for (int i = 0; i < TO; i++) begin
                set_exp(PH_WOUT, 0);
                step();
            end
            model_err = 1'b1;
            set_exp(PH_IDLE, 0);
            step();
            return;
        end
        for (int i = 0; i <= d3; i++) begin
            set_exp(PH_WOUT, 0);
            output_done = (i == d3);
            if (noisy) begin
                mem_to_fifo_done = 1'($urandom_range(0, 1));
                fifo_to_arr_done = 1'($urandom_range(0, 1));
                start            = 1'($urandom_range(0, 1));
            end
            step();
        end
        clear_noise();
        set_exp(PH_DONE, 0);
        if (noisy) start = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        set_exp(PH_IDLE, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cur_wb = '0;
        cur_ib = '0;
        cur_ob = '0;
        reset_counts();
        set_exp(PH_IDLE, 0);
        #1;
        step();
        step();
        reset = 1'b0;
        step();

        // Basic pass
        reset_counts();
        run_pass(8'h00, 8'h00, 8'h00, 1, 1, 1, 1'b0, -1);
        cmp("basic_m2f_cycles", BW'(m2f_cycles), BW'(16));
        cmp("basic_active_cycles", BW'(active_cycles), BW'(19));
        cmp("basic_done_count", BW'(done_count), BW'(1));
        cmp("basic_first_addr", BW'(addr_log[0]), BW'(8'h00));
        cmp("basic_last_addr", BW'(addr_log[15]), BW'(8'h0F));

        // Bases 0x20
        reset_counts();
        run_pass(8'h20, 8'h20, 8'h20, 1, 2, 0, 1'b0, -1);
        cmp("b20_first_addr", BW'(addr_log[0]), BW'(8'h20));
        cmp("b20_last_addr", BW'(addr_log[15]), BW'(8'h2F));
        cmp("b20_in_base", ibus_seen, {16{8'h20}});

        // Address wrap
        reset_counts();
        run_pass(8'hF8, 8'h01, 8'h02, 0, 0, 0, 1'b0, -1);
        cmp("wrap_addr7", BW'(addr_log[7]), BW'(8'hFF));
        cmp("wrap_addr8", BW'(addr_log[8]), BW'(8'h00));
        cmp("wrap_addr15", BW'(addr_log[15]), BW'(8'h07));

        // Ignored events: stray done strobes and start while busy
        reset_counts();
        run_pass(8'h40, 8'h41, 8'h42, 2, 3, 2, 1'b1, -1);
        cmp("noisy_done_count", BW'(done_count), BW'(1));
        cmp("noisy_active_cycles", BW'(active_cycles), BW'(19));

        // Reset mid-COMPUTE, then a full pass
        reset_counts();
        run_pass(8'h10, 8'h11, 8'h12, 1, 1, 1, 1'b0, 7);
        cmp("abort_done_count", BW'(done_count), BW'(0));
        run_pass(8'h11, 8'h22, 8'h33, 1, 1, 1, 1'b0, -1);
        cmp("after_abort_done_count", BW'(done_count), BW'(1));

`ifdef SEQ_TIMEOUT_EN
        reset_counts();
        run_pass(8'h33, 8'h44, 8'h55, 1, 1, -1, 1'b0, -1);
        cmp("timeout_error", BW'(error), BW'(1'b1));
        cmp("timeout_done_count", BW'(done_count), BW'(0));
        run_pass(8'h05, 8'h06, 8'h07, 0, 0, 0, 1'b0, -1);
        cmp("error_cleared", BW'(error), BW'(1'b0));
`else
        reset_counts();
        run_pass(8'h33, 8'h44, 8'h55, 3, 2, 80, 1'b0, -1);
        cmp("stall_done_count", BW'(done_count), BW'(1));
`endif

        for (int p = 0; p < 8; p++) begin
            run_pass(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
